time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
// Button front-end for the h/m/s timekeeping counter: turns raw Basys3 push-buttons into
// the setting controls that counter consumes (set_h/set_m/set_s field select, set_signal
// single-step pulse, btn_long_signal auto-repeat pulse). Sits between board pins and the
// timer in the same clk domain; all outputs are registered and glitch-free.
// PARAMETERS
// DEB_CYC   1_000_000    cycles a synced input must differ from debounced level to flip it
// LONG_CYC  100_000_000  cycles from set_signal pulse to first btn_long_signal pulse
// REP_CYC   20_000_000   cycles between successive btn_long_signal pulses while held
// CNT_W     27           width of debounce/hold counters; must hold max(DEB,LONG,REP)
// PORTS
// clk              in   1  system clock, all logic rising-edge
// reset_n          in   1  asynchronous, active-low reset
// btn_mode         in   1  raw async button: cycle field select
// btn_inc          in   1  raw async button: increment selected field
// set_h            out  1  hours field selected (one-hot with set_m/set_s, or all 0)
// set_m            out  1  minutes field selected
// set_s            out  1  seconds field selected
// set_signal       out  1  1-cycle pulse: single increment request
// btn_long_signal  out  1  1-cycle pulse: auto-repeat increment request
// BEHAVIOUR
// - Reset (reset_n=0, async): all outputs 0, mode FSM=RUN, inc FSM=IDLE, debounced levels 0,
//   sync flops 0, counters 0. Release is sampled on the next clk edge.
// - Each button: 2-FF synchroniser, then debounce: counter increments each cycle sync!=db,
//   clears when sync==db; db flips on the edge the counter reaches DEB_CYC (then clears).
//   Bounces shorter than DEB_CYC never change db. Rise edge = db & ~db_q (1 cycle).
// - Mode FSM, advanced only on btn_mode debounced rise: RUN -> SET_H -> SET_M -> SET_S -> RUN.
//   Outputs: RUN=000, SET_H=set_h, SET_M=set_m, SET_S=set_s; at most one high ever.
// - Inc FSM states IDLE, HOLD, REPEAT, WAIT_REL:
//   IDLE: on inc rise with mode!=RUN -> set_signal=1 next cycle, hold_cnt=0, go HOLD.
//     inc rise in RUN -> no pulse, go WAIT_REL.
//   HOLD: hold_cnt++ per cycle; on reaching LONG_CYC -> btn_long_signal=1 that next cycle,
//     hold_cnt=0, go REPEAT. db_inc=0 -> IDLE (no long pulse).
//   REPEAT: hold_cnt++; each time it reaches REP_CYC -> btn_long_signal pulse, cnt=0.
//     db_inc=0 -> IDLE.
//   WAIT_REL: no pulses; db_inc=0 -> IDLE.
// - Mode rise while inc FSM in HOLD/REPEAT: mode advances, inc FSM -> WAIT_REL same edge,
//   any pulse due that cycle is suppressed (no increment lands on the new field).
// - Mode rise and inc rise same cycle: mode update wins; inc FSM -> WAIT_REL, no set_signal.
// - set_signal and btn_long_signal are never high in the same cycle; each high exactly 1 cycle.
// - Latency: raw edge -> db flip = 2 + DEB_CYC cycles; db rise -> set_signal = 1 cycle.
// - Counters saturate-free: clear on reaching terminal value, never wrap through 0 silently.
// - Reset mid-hold: immediate return to reset state; no pulse emitted after reset release
//   until a fresh debounced rise (button held through reset requires release first: db
//   starts 0, so held button yields one rise after DEB_CYC -> treated as a new press).
// TESTING  (bench params DEB_CYC=4, LONG_CYC=20, REP_CYC=5)
// 1 Reset, 3 clean btn_mode presses -> set_h, then set_m, then set_s; 4th press -> all 0.
// 2 btn_inc bounce 1-0-1-0 at 2-cycle spacing, then stable 1 in SET_M -> exactly one
//   set_signal, 2+4+1 cycles after the stable edge; no btn_long_signal if released <20 cyc.
// 3 SET_H, hold btn_inc 50 cycles after set_signal -> btn_long_signal at +20,+25,+30,...,+50
//   (7 pulses); release -> pulses stop within debounce latency.
// 4 RUN mode, press/hold btn_inc 60 cycles -> no set_signal, no btn_long_signal.
// 5 SET_S, btn_inc held in REPEAT, press btn_mode -> mode RUN, no further long pulses
//   until btn_inc released and pressed again.
// 6 Assert reset_n=0 mid-REPEAT for 1 cycle -> outputs 0 asynchronously, mode RUN; with
//   btn_inc still held, no pulse (mode RUN); one-hot/one-pulse assertions checked throughout.

Source files
------------

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounces the mode/inc push-buttons into h/m/s field select plus single-step and auto-repeat increment pulses.
// Latency: raw edge -> debounced level 2+DEB_CYC cycles; debounced inc rise -> set_signal 1 cycle; all outputs registered.
// Backpressure: none; set_signal/btn_long_signal are 1-cycle pulses the counter must sample every cycle.
module time_set_ctrl #(
    parameter int DEB_CYC  = 1_000_000,
    parameter int LONG_CYC = 100_000_000,
    parameter int REP_CYC  = 20_000_000,
    parameter int CNT_W    = 27
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_mode,
    input  logic btn_inc,
    output logic set_h,
    output logic set_m,
    output logic set_s,
    output logic set_signal,
    output logic btn_long_signal
);

    // Counters compare against terminal-1 so the flip/pulse lands on the edge the count reaches terminal.
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    // Bit 0 is the mode button, bit 1 the inc button.
    localparam int MODE_B = 0;
    localparam int INC_B  = 1;

    typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} mode_t;
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} inc_t;

    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       db;
    logic [1:0]       db_q;
    logic [CNT_W-1:0] deb_cnt [2];

    mode_t            mode_st;
    inc_t             inc_st;
    logic [CNT_W-1:0] hold_cnt;

    logic             mode_rise;
    logic             inc_rise;
    logic             db_inc;

    assign raw       = {btn_inc, btn_mode};
    assign mode_rise = db[MODE_B] & ~db_q[MODE_B];
    assign inc_rise  = db[INC_B] & ~db_q[INC_B];
    assign db_inc    = db[INC_B];

    // Two-flop synchroniser and per-button debounce: level flips only after DEB_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    db[i]      <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Field-select FSM: each debounced mode press steps RUN -> H -> M -> S -> RUN; select lines registered alongside.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_st <= RUN;
            set_h   <= 1'b0;
            set_m   <= 1'b0;
            set_s   <= 1'b0;
        end else if (mode_rise) begin
            case (mode_st)
                RUN: begin
                    mode_st <= SET_H;
                    {set_h, set_m, set_s} <= 3'b100;
                end
                SET_H: begin
                    mode_st <= SET_M;
                    {set_h, set_m, set_s} <= 3'b010;
                end
                SET_M: begin
                    mode_st <= SET_S;
                    {set_h, set_m, set_s} <= 3'b001;
                end
                SET_S: begin
                    mode_st <= RUN;
                    {set_h, set_m, set_s} <= 3'b000;
                end
            endcase
        end
    end

    // Increment FSM: single step on press, auto-repeat while held; a mode change kills the press until release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_st          <= IDLE;
            hold_cnt        <= '0;
            set_signal      <= 1'b0;
            btn_long_signal <= 1'b0;
        end else begin
            set_signal      <= 1'b0;
            btn_long_signal <= 1'b0;
            case (inc_st)
                IDLE: begin
                    if (inc_rise) begin
                        if (mode_rise || mode_st == RUN) begin
                            inc_st <= WAIT_REL;
                        end else begin
                            set_signal <= 1'b1;
                            hold_cnt   <= '0;
                            inc_st     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (mode_rise) begin
                        inc_st <= WAIT_REL;
                    end else if (!db_inc) begin
                        inc_st <= IDLE;
                    end else if (hold_cnt == LONG_LAST) begin
                        btn_long_signal <= 1'b1;
                        hold_cnt        <= '0;
                        inc_st          <= REPEAT;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (mode_rise) begin
                        inc_st <= WAIT_REL;
                    end else if (!db_inc) begin
                        inc_st <= IDLE;
                    end else if (hold_cnt == REP_LAST) begin
                        btn_long_signal <= 1'b1;
                        hold_cnt        <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end
                WAIT_REL: begin
                    if (!db_inc) begin
                        inc_st <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: table-driven presses, hand-written corner sequences and random button activity for time_set_ctrl.
// Every cycle the outputs are compared against a press-level reference model with small timing constants.
// Also checks one-hot field select and mutually exclusive 1-cycle pulses throughout.
module tb_time_set_ctrl;

    localparam int DEB    = 4;
    localparam int LONG   = 20;
    localparam int REP    = 5;
    localparam int SETTLE = 14;

    logic clk;
    logic reset_n;
    logic btn_mode;
    logic btn_inc;
    logic set_h;
    logic set_m;
    logic set_s;
    logic set_signal;
    logic btn_long_signal;

    time_set_ctrl #(
        .DEB_CYC (DEB),
        .LONG_CYC(LONG),
        .REP_CYC (REP),
        .CNT_W   (27)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .btn_mode       (btn_mode),
        .btn_inc        (btn_inc),
        .set_h          (set_h),
        .set_m          (set_m),
        .set_s          (set_s),
        .set_signal     (set_signal),
        .btn_long_signal(btn_long_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_set    = 0;
    int n_long   = 0;

    // Reference model state: raw sample history, debounced levels, field index, live press and its age.
    bit [7:0] hist_m;
    bit [7:0] hist_i;
    bit       m_db_m, m_db_i, m_dbq_m, m_dbq_i;
    int       m_field;
    bit       m_live;
    int       m_age;
    bit       m_set;
    bit       m_long;

    function automatic bit flip_due(input bit [7:0] h, input bit lvl);
        // h[0] = raw sampled last edge; h[1+j] = synchronised sample seen j edges ago.
        for (int j = 0; j < DEB; j++) begin
            if (h[1 + j] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [2:0] field_bits(input int f);
        case (f)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        hist_m  = '0;
        hist_i  = '0;
        m_db_m  = 0;
        m_db_i  = 0;
        m_dbq_m = 0;
        m_dbq_i = 0;
        m_field = 0;
        m_live  = 0;
        m_age   = 0;
        m_set   = 0;
        m_long  = 0;
    endtask

    task automatic model_edge();
        bit mr;
        bit ir;
        if (!reset_n) begin
            model_reset();
            return;
        end
        mr     = m_db_m & ~m_dbq_m;
        ir     = m_db_i & ~m_dbq_i;
        m_set  = 0;
        m_long = 0;
        if (mr) begin
            m_field = (m_field + 1) % 4;
            m_live  = 0;
        end else if (ir) begin
            m_live = 0;
            if (m_field != 0) begin
                m_live = 1;
                m_age  = 0;
                m_set  = 1;
            end
        end else if (m_live) begin
            if (!m_db_i) begin
                m_live = 0;
            end else begin
                m_age++;
                if (m_age >= LONG && (m_age - LONG) % REP == 0) m_long = 1;
            end
        end
        m_dbq_m = m_db_m;
        m_dbq_i = m_db_i;
        if (flip_due(hist_m, m_db_m)) m_db_m = ~m_db_m;
        if (flip_due(hist_i, m_db_i)) m_db_i = ~m_db_i;
        hist_m = {hist_m[6:0], btn_mode};
        hist_i = {hist_i[6:0], btn_inc};
    endtask

    task automatic check_cycle(input string tag);
        logic [4:0] act;
        logic [4:0] exp;
        act = {set_h, set_m, set_s, set_signal, btn_long_signal};
        exp = {m_field == 1, m_field == 2, m_field == 3, m_set, m_long};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d hms_set_long got=%b want=%b", tag, cyc, act, exp);
        end
        checks++;
        if ($countones({set_h, set_m, set_s}) > 1 || (set_signal && btn_long_signal)) begin
            failures++;
            $display("FAIL invariant cyc=%0d hms=%b set=%b long=%b want onehot0/exclusive",
                     cyc, {set_h, set_m, set_s}, set_signal, btn_long_signal);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_cycle("model");
        if (set_signal) n_set++;
        if (btn_long_signal) n_long++;
    endtask

    task automatic expect_int(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic expect_field(input string tag, input int want);
        checks++;
        if ({set_h, set_m, set_s} !== field_bits(want)) begin
            failures++;
            $display("FAIL %s field got=%b want=%b", tag, {set_h, set_m, set_s}, field_bits(want));
        end
    endtask

    // sel: 0 = mode, 1 = inc, 2 = both together; hold = raw-high cycles.
    task automatic press(input int sel, input int hold);
        n_set  = 0;
        n_long = 0;
        if (sel != 1) btn_mode = 1'b1;
        if (sel != 0) btn_inc = 1'b1;
        repeat (hold) tick();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (SETTLE) tick();
    endtask

    typedef struct {
        string name;
        int    sel;
        int    hold;
        int    exp_field;
        int    exp_set;
        int    exp_long;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input string name, input int sel, input int hold,
                           input int f, input int s, input int l);
        vec_t v;
        v.name      = name;
        v.sel       = sel;
        v.hold      = hold;
        v.exp_field = f;
        v.exp_set   = s;
        v.exp_long  = l;
        tbl.push_back(v);
    endtask

    initial begin
        int lat;

        // Inc presses: set at raw-edge+7, long pulses at +27,+32,... while debounced level (falls at hold+6) is high.
        add_vec("mode_to_h",      0, 10, 1, 0, 0);
        add_vec("mode_to_m",      0, 10, 2, 0, 0);
        add_vec("mode_to_s",      0, 10, 3, 0, 0);
        add_vec("mode_to_run",    0, 10, 0, 0, 0);
        add_vec("inc_in_run",     1, 60, 0, 0, 0);
        add_vec("mode_bounce3",   0,  3, 0, 0, 0);
        add_vec("mode_exact4",    0,  4, 1, 0, 0);
        add_vec("inc_short",      1, 10, 1, 1, 0);
        add_vec("inc_hold20",     1, 20, 1, 1, 0);
        add_vec("inc_hold21",     1, 21, 1, 1, 1);
        add_vec("inc_hold51",     1, 51, 1, 1, 7);
        add_vec("inc_bounce3",    1,  3, 1, 0, 0);
        add_vec("both_same_cyc",  2, 30, 2, 0, 0);
        add_vec("inc_hold26_m",   1, 26, 2, 1, 2);

        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        expect_field("reset_field", 0);
        expect_int("reset_set", int'(set_signal), 0);
        expect_int("reset_long", int'(btn_long_signal), 0);

        foreach (tbl[k]) begin
            press(tbl[k].sel, tbl[k].hold);
            expect_field({tbl[k].name, "_field"}, tbl[k].exp_field);
            expect_int({tbl[k].name, "_nset"}, n_set, tbl[k].exp_set);
            expect_int({tbl[k].name, "_nlong"}, n_long, tbl[k].exp_long);
        end

        // Bouncy inc press in SET_M: one set_signal, 7 cycles after the stable edge, no long pulse.
        n_set  = 0;
        n_long = 0;
        for (int b = 0; b < 8; b++) begin
            btn_inc = (b % 4 < 2) ? 1'b1 : 1'b0;
            tick();
        end
        btn_inc = 1'b1;
        lat     = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (set_signal) begin
                lat = k;
                break;
            end
        end
        expect_int("bounce_latency", lat, 7);
        repeat (5) tick();
        btn_inc = 1'b0;
        repeat (SETTLE) tick();
        expect_int("bounce_nset", n_set, 1);
        expect_int("bounce_nlong", n_long, 0);

        // SET_S, inc held into auto-repeat, then a mode press: back to RUN and the held press goes quiet.
        press(0, 10);
        expect_field("to_s_again", 3);
        btn_inc = 1'b1;
        repeat (40) tick();
        btn_mode = 1'b1;
        repeat (10) tick();
        btn_mode = 1'b0;
        repeat (10) tick();
        expect_field("mode_during_repeat", 0);
        n_set  = 0;
        n_long = 0;
        repeat (30) tick();
        expect_int("held_after_mode_nlong", n_long, 0);
        btn_inc = 1'b0;
        repeat (SETTLE) tick();
        press(1, 30);
        expect_int("repress_in_run_npulse", n_set + n_long, 0);

        // Reset asserted mid-repeat: outputs clear without a clock edge; held button afterwards gives nothing.
        press(0, 10);
        expect_field("to_h_for_reset", 1);
        btn_inc = 1'b1;
        repeat (35) tick();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_cycle("async_reset");
        tick();
        reset_n = 1'b1;
        n_set   = 0;
        n_long  = 0;
        repeat (40) tick();
        expect_int("post_reset_npulse", n_set + n_long, 0);
        expect_field("post_reset_field", 0);
        btn_inc = 1'b0;
        repeat (SETTLE) tick();

        // Random button activity, short segments so bounces, simultaneous rises and mode-during-hold all occur.
        for (int s = 0; s < 250; s++) begin
            btn_mode = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
            btn_inc  = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            repeat ($urandom_range(1, 28)) tick();
        end
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (SETTLE) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
